// File: rtl/ones_count_sched.sv
// ones_count_sched: round-robin scheduler sharing one ones-counter engine among NUM_REQ
// requesters. A winning requester's word is issued to the engine and the count is returned
// tagged with the requester id. All outputs are registered.
// Optional feature: define ONES_SCHED_TIMEOUT_EN to enable a watchdog that aborts a job
// after TIMEOUT_CYC waiting cycles and reports it with resp_err.

module ones_count_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 32,
    parameter int unsigned IDW         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      resp_valid,
    output logic [IDW-1:0]            resp_id,
    output logic [CNT_W-1:0]          resp_count,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_data,
    input  logic                      eng_rdy,
    input  logic [CNT_W-1:0]          eng_count
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

    state_e state_q, state_d;

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic [CNT_W-1:0]   resp_count_q, resp_count_d;
    logic               resp_err_q, resp_err_d;
    logic               busy_q, busy_d;
    logic               eng_start_q, eng_start_d;
    logic [DATA_W-1:0]  eng_data_q, eng_data_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     grant_nxt;
    logic [DATA_W-1:0]  grant_data;
    logic               timeout;

    // Round-robin search starting at ptr, wrapping mod NUM_REQ.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        idx         = 0;
        nxt         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req[idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = idx[IDW-1:0];
            end
        end
        nxt = 32'(grant_id) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
        grant_nxt  = nxt[IDW-1:0];
        grant_data = req_data[32'(grant_id) * DATA_W +: DATA_W];
    end

`ifdef ONES_SCHED_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    logic [WdW-1:0] wd_q, wd_d;

    assign timeout = (state_q == StWaitBusy || state_q == StWaitDone) &&
                     (wd_q == WdW'(TIMEOUT_CYC - 1));

    // Watchdog counts waiting cycles; every (re-)issue restarts it.
    always_comb begin
        wd_d = wd_q;
        if (state_d == StIssue) begin
            wd_d = '0;
        end else if (state_q == StWaitBusy || state_q == StWaitDone) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (grant_found && eng_rdy) state_d = StIssue;
            StIssue:    state_d = StWaitBusy;
            // Engine still ready here means it missed the start: issue again.
            StWaitBusy: begin
                if (eng_rdy)      state_d = StIssue;
                else if (timeout) state_d = StIdle;
                else              state_d = StWaitDone;
            end
            StWaitDone: if (eng_rdy || timeout) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        ptr_d        = ptr_q;
        cur_id_d     = cur_id_q;
        ack_d        = '0;
        eng_start_d  = 1'b0;
        eng_data_d   = eng_data_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_count_d = resp_count_q;
        resp_err_d   = resp_err_q;
        busy_d       = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (grant_found && eng_rdy) begin
                    ptr_d           = grant_nxt;
                    cur_id_d        = grant_id;
                    eng_data_d      = grant_data;
                    ack_d[grant_id] = 1'b1;
                    eng_start_d     = 1'b1;
                end
            end
            StIssue: ;
            StWaitBusy: begin
                if (eng_rdy) begin
                    eng_start_d = 1'b1;
                end else if (timeout) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = cur_id_q;
                    resp_count_d = '1;
                    resp_err_d   = 1'b1;
                end
            end
            StWaitDone: begin
                if (eng_rdy) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = cur_id_q;
                    resp_count_d = eng_count;
                    resp_err_d   = 1'b0;
                end else if (timeout) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = cur_id_q;
                    resp_count_d = '1;
                    resp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            cur_id_q     <= '0;
            ack_q        <= '0;
            eng_start_q  <= 1'b0;
            eng_data_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_count_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            cur_id_q     <= cur_id_d;
            ack_q        <= ack_d;
            eng_start_q  <= eng_start_d;
            eng_data_q   <= eng_data_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_count_q <= resp_count_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ack        = ack_q;
    assign eng_start  = eng_start_q;
    assign eng_data   = eng_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_count = resp_count_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule
